// File: rtl/nibble_pair_pkg.sv
// nibble_pair_pkg: shared state encoding and widths for the nibble pairing block
package nibble_pair_pkg;
  localparam int NIBBLE_W = 4;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;
endpackage

// File: rtl/nibble_pair_ctrl_concat.sv
// nibble_pair_ctrl_concat: joins two nibbles into a byte with a in the upper half
module nibble_pair_ctrl_concat
  import nibble_pair_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  output logic [BYTE_W-1:0]   ab
);
  assign ab = {a, b};
endmodule

// File: rtl/nibble_pair_ctrl.sv
// nibble_pair_ctrl: pairs a nibble stream into bytes with valid/ready handshakes on both sides
module nibble_pair_ctrl
  import nibble_pair_pkg::*;
#(
  parameter bit HI_FIRST = 1'b1,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NIBBLE_W-1:0] in_nibble,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BYTE_W-1:0]   out_byte,
  output logic                out_pad,
  output logic [CNT_W-1:0]    byte_count,
  output logic                busy
);
  state_t state, state_nx;
  logic [NIBBLE_W-1:0] first, second;
  logic acc, consume, load_first, load_second;
  assign in_ready = (state != FULL) || out_ready;
  assign acc = in_valid && in_ready;
  assign consume = (state == FULL) && out_ready;
  assign load_first = acc && (state == EMPTY || state == FULL);
  assign load_second = acc && (state == HALF);
  assign out_valid = state == FULL;
  assign busy = state != EMPTY;
  // Next state: a consumed FULL behaves like EMPTY for the nibble accepted alongside it
  always_comb begin
    state_nx = EMPTY;
    state_nx = load_first ? (in_last ? FULL : HALF)
             : (state == HALF) ? (acc ? FULL : HALF)
             : (state == FULL) ? (out_ready ? EMPTY : FULL)
             : EMPTY;
  end
  // State, nibble storage, pad flag and consumed-byte counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      first <= '0;
      second <= '0;
      out_pad <= 1'b0;
      byte_count <= '0;
    end else begin
      state <= state_nx;
      if (load_first) begin
        first <= in_nibble;
        second <= '0;
        out_pad <= in_last;
      end else if (load_second) begin
        second <= in_nibble;
        out_pad <= 1'b0;
      end
      if (consume) byte_count <= byte_count + CNT_W'(1);
    end
  end
  nibble_pair_ctrl_concat u_concat (
    .a (HI_FIRST ? first : second),
    .b (HI_FIRST ? second : first),
    .ab(out_byte)
  );
endmodule

// File: tb/tb_nibble_pair_ctrl.sv
// tb_nibble_pair_ctrl: directed checks of nibble pairing, padding, backpressure, reset and count wrap
module tb_nibble_pair_ctrl;
  logic clk = 1'b0;
  logic reset, in_valid, in_last, out_ready;
  logic [3:0] in_nibble;
  logic in_ready, out_valid, out_pad, busy;
  logic [7:0] out_byte;
  logic [3:0] byte_count;
  logic in_ready_b, out_valid_b, out_pad_b, busy_b;
  logic [7:0] out_byte_b, byte_count_b;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  nibble_pair_ctrl #(.HI_FIRST(1'b1), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_nibble(in_nibble), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_byte(out_byte), .out_pad(out_pad),
    .byte_count(byte_count), .busy(busy)
  );
  nibble_pair_ctrl #(.HI_FIRST(1'b0), .CNT_W(8)) dut_lo (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_nibble(in_nibble), .in_last(in_last), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_byte(out_byte_b), .out_pad(out_pad_b),
    .byte_count(byte_count_b), .busy(busy_b)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [3:0] n, input logic last);
    in_valid = 1'b1;
    in_nibble = n;
    in_last = last;
    step();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  initial begin
    logic [3:0] a, b;
    reset = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_nibble = 4'h0;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_byte", 32'(out_byte), 32'h00);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pad", 32'(out_pad), 32'd0);
    chk("rst_count", 32'(byte_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    step();
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    send(4'hA, 1'b0);
    chk("half_busy", 32'(busy), 32'd1);
    chk("half_valid", 32'(out_valid), 32'd0);
    send(4'h5, 1'b0);
    chk("a5_valid", 32'(out_valid), 32'd1);
    chk("a5_byte", 32'(out_byte), 32'hA5);
    chk("a5_pad", 32'(out_pad), 32'd0);
    chk("a5_lo_byte", 32'(out_byte_b), 32'h5A);
    step();
    chk("a5_done_valid", 32'(out_valid), 32'd0);
    chk("a5_count", 32'(byte_count), 32'd1);
    send(4'h3, 1'b0);
    send(4'hC, 1'b0);
    chk("3c_byte", 32'(out_byte), 32'h3C);
    chk("3c_lo_byte", 32'(out_byte_b), 32'hC3);
    step();
    chk("3c_count", 32'(byte_count), 32'd2);
    out_ready = 1'b0;
    send(4'h7, 1'b1);
    chk("pad_valid", 32'(out_valid), 32'd1);
    chk("pad_byte", 32'(out_byte), 32'h70);
    chk("pad_flag", 32'(out_pad), 32'd1);
    chk("pad_lo_byte", 32'(out_byte_b), 32'h07);
    out_ready = 1'b1;
    step();
    chk("pad_count", 32'(byte_count), 32'd3);
    out_ready = 1'b0;
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    in_valid = 1'b1;
    in_nibble = 4'h9;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", 32'(in_ready), 32'd0);
      chk("bp_byte", 32'(out_byte), 32'h12);
      chk("bp_valid", 32'(out_valid), 32'd1);
      step();
    end
    chk("bp_count_held", 32'(byte_count), 32'd3);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_count", 32'(byte_count), 32'd4);
    step();
    chk("bp_one_transfer", 32'(byte_count), 32'd4);
    send(4'hF, 1'b0);
    chk("rst_half_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    chk("rst_half_state", 32'(busy), 32'd0);
    chk("rst_half_count", 32'(byte_count), 32'd0);
    reset = 1'b0;
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    chk("rst_half_byte", 32'(out_byte), 32'h12);
    step();
    chk("rst_half_after", 32'(byte_count), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int j = 0; j < 16; j++) begin
      a = 4'(2 * j + 1);
      b = 4'(2 * j + 2);
      in_nibble = a;
      step();
      in_nibble = b;
      step();
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_byte", 32'(out_byte), 32'({a, b}));
      chk("stream_count", 32'(byte_count), 32'(j));
    end
    in_valid = 1'b0;
    step();
    chk("wrap_count", 32'(byte_count), 32'd0);
    chk("wrap_valid", 32'(out_valid), 32'd0);
    chk("wrap_lo_count", 32'(byte_count_b), 32'd16);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
